aes_round_key_gen: RTL and testbench
====================================

// Module: aes_round_key_gen
// PURPOSE
//  - On-the-fly AES-128 key schedule. Feeds the AES_128 round datapath one 128-bit round key per round.
//  - Expands the master key iteratively, one 32-bit word per cycle, using a single SubWord unit.
//  - The consumer pulls keys in round order (0..NR) over a valid/ready handshake.
// PARAMETERS
//  - KEY_W  128  key and round-key width in bits; only 128 is supported
//  - NR     10   last round index; round keys 0..NR are produced (11 keys)
// PORTS
//  - clk          in   1    single clock; all state updates on posedge
//  - rst          in   1    asynchronous, active-high reset
//  - start_i      in   1    1-cycle pulse; captures key_i; accepted only in IDLE
//  - key_i        in   128  master key, word 0 = bits [127:96]
//  - replay_i     in   1    1-cycle pulse; replays cached keys (AES_RK_CACHE_EN only)
//  - rk_o         out  128  current round key; meaningful only while rk_valid_o=1
//  - rk_round_o   out  4    round index of rk_o (0..NR)
//  - rk_valid_o   out  1    rk_o holds a complete round key
//  - rk_ready_i   in   1    consumer accepts rk_o when rk_valid_o & rk_ready_i
//  - busy_o       out  1    high in every state except IDLE
//  - done_o       out  1    1-cycle pulse after round NR key accepted
// BEHAVIOUR
//  - Reset values:
//      - rk_o = 0, rk_round_o = 0, rk_valid_o = 0, busy_o = 0, done_o = 0
//      - FSM = IDLE, word counter = 0, cache_valid = 0
//  - FSM states: IDLE, HOLD, EXPAND.
//  - IDLE
//      - start_i: next cycle rk_o = key_i, rk_round_o = 0, rk_valid_o = 1, go to HOLD.
//      - start_i and replay_i together: start_i wins.
//  - HOLD
//      - rk_valid_o = 1. rk_o and rk_round_o are stable until the handshake.
//      - Handshake with rk_round_o == NR: rk_valid_o = 0, done_o pulses next cycle, go to IDLE.
//      - Handshake otherwise: rk_valid_o = 0, go to EXPAND with wcnt = 0.
//  - EXPAND (4 cycles, wcnt 0..3, working register = rk_o words w0..w3)
//      - wcnt 0: w0 <= w0 ^ SubWord(RotWord(w3)) ^ {RCON[rk_round_o+1], 24'h0}
//      - wcnt 1..3: wk <= wk ^ w(k-1), using the already-updated w(k-1)
//      - After wcnt 3: rk_round_o++, rk_valid_o = 1, go to HOLD.
//      - rk_o shows partial words while rk_valid_o = 0.
//  - Timing
//      - Key 0 is valid 1 cycle after start_i.
//      - Key i+1 is valid 5 cycles after key i is accepted.
//      - With rk_ready_i held high: one key every 5 cycles; done_o 52 cycles after start_i.
//  - Boundaries
//      - start_i while busy_o: ignored.
//      - rk_ready_i without rk_valid_o: ignored.
//      - rk_round_o never exceeds NR and does not wrap.
//      - Reset mid-operation returns to reset values immediately; no partial key survives.
// CONFIGURATION
//  - Macro AES_RK_CACHE_EN defined
//      - Adds an 11 x 128 cache. Each key is written to cache[rk_round_o] when it becomes valid.
//      - cache_valid sets once key NR is written; it clears on start_i.
//      - replay_i in IDLE with cache_valid: keys 0..NR are streamed from the cache.
//      - Replay has no EXPAND phase. The next key is valid the cycle after each handshake, so ready held high gives 1 key/cycle.
//      - done_o and busy_o behave as in a normal run.
//  - Macro undefined
//      - No cache is built. replay_i is ignored and the port remains present.
// STRUCTURE
//  - Package aes_pkg holds:
//      - RCON[1:10] table
//      - FSM state enum (IDLE/HOLD/EXPAND)
//      - KEY_W, NR and word-width constants
//  - Sub-module aes_sbox: combinational byte S-box, 4 instances form SubWord.
//      - Shared with the SubBytes stage of AES_128.
// TESTING
//  - FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i = 1:
//      - round 0 = key
//      - round 1 = a0fafe1788542cb123a339392a6c7605
//      - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
//      - done_o at cycle 52
//  - Backpressure: drop rk_ready_i for 7 cycles at round 3.
//      - rk_o and rk_round_o stay stable.
//      - Sequence is unchanged; each stall delays all later keys by the same count.
//  - start_i pulsed at round 5 while busy: ignored, keys unchanged.
//      - After done_o, a new start_i with key 0 gives round 1 = 62636363626363636263636362636363.
//  - Assert rst during EXPAND of round 4:
//      - all outputs 0 in the same cycle
//      - next start_i restarts cleanly from round 0
//  - AES_RK_CACHE_EN:
//      - replay_i after a full run gives 11 keys on 11 consecutive cycles, identical to the first run.
//      - replay_i before any completed run: no response.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, round constants and FSM state type
package aes_pkg;

    localparam int KEY_W  = 128;
    localparam int NR     = 10;
    localparam int WORD_W = 32;
    localparam int RND_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        EXPAND = 2'd2
    } state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for the key being built; out-of-range indices read as zero
    function automatic logic [7:0] rcon_lookup(input logic [RND_W-1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box (GF(2^8) inverse followed by the affine map)
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    logic [7:0] inv;

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    always_comb begin
        x2   = gf_mul(a_i, a_i);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_round_key_gen.sv
// rtl/aes_round_key_gen.sv - on-the-fly AES-128 round key generator, optional key cache under AES_RK_CACHE_EN
module aes_round_key_gen #(
    parameter int KEY_W = 128,
    parameter int NR    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             replay_i,
    output logic [KEY_W-1:0] rk_o,
    output logic [3:0]       rk_round_o,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic             busy_o,
    output logic             done_o
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   rk_q, rk_d;
    logic [3:0]         round_q, round_d;
    logic [1:0]         wcnt_q, wcnt_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  w0, w1, w2, w3, rot_w, sub_w;
    logic               handshake;

`ifdef AES_RK_CACHE_EN
    logic [KEY_W-1:0]   cache_q [0:NR];
    logic               cache_valid_q, cache_valid_d;
    logic               replay_q, replay_d;
`else
    logic               unused_replay;
    assign unused_replay = replay_i;
`endif

    assign w0    = rk_q[127:96];
    assign w1    = rk_q[95:64];
    assign w2    = rk_q[63:32];
    assign w3    = rk_q[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.a_i(rot_w[31:24]), .s_o(sub_w[31:24]));
    aes_sbox u_sbox1 (.a_i(rot_w[23:16]), .s_o(sub_w[23:16]));
    aes_sbox u_sbox2 (.a_i(rot_w[15:8]),  .s_o(sub_w[15:8]));
    aes_sbox u_sbox3 (.a_i(rot_w[7:0]),   .s_o(sub_w[7:0]));

    assign handshake  = (state_q == HOLD) && rk_ready_i;
    assign rk_o       = rk_q;
    assign rk_round_o = round_q;
    assign rk_valid_o = (state_q == HOLD);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

    // Next-state: capture, hold for handshake, then rebuild the four words in place
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
`ifdef AES_RK_CACHE_EN
        cache_valid_d = cache_valid_q;
        replay_d      = replay_q;
        if (state_q == HOLD && !replay_q && round_q == LAST_RND) begin
            cache_valid_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rk_d    = key_i;
                    round_d = 4'd0;
                    state_d = HOLD;
`ifdef AES_RK_CACHE_EN
                    cache_valid_d = 1'b0;
                    replay_d      = 1'b0;
                end else if (replay_i && cache_valid_q) begin
                    rk_d     = cache_q[0];
                    round_d  = 4'd0;
                    state_d  = HOLD;
                    replay_d = 1'b1;
`endif
                end
            end
            HOLD: begin
                if (handshake) begin
                    if (round_q == LAST_RND) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef AES_RK_CACHE_EN
                    end else if (replay_q) begin
                        rk_d    = cache_q[round_q + 4'd1];
                        round_d = round_q + 4'd1;
`endif
                    end else begin
                        state_d = EXPAND;
                        wcnt_d  = 2'd0;
                    end
                end
            end
            EXPAND: begin
                case (wcnt_q)
                    2'd0:    rk_d[127:96] = w0 ^ sub_w ^ {rcon_lookup(round_q + 4'd1), 24'h0};
                    2'd1:    rk_d[95:64]  = w1 ^ w0;
                    2'd2:    rk_d[63:32]  = w2 ^ w1;
                    default: rk_d[31:0]   = w3 ^ w2;
                endcase
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) begin
                    round_d = round_q + 4'd1;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any partially built key immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= 4'd0;
            wcnt_q  <= 2'd0;
            done_q  <= 1'b0;
`ifdef AES_RK_CACHE_EN
            cache_valid_q <= 1'b0;
            replay_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
`ifdef AES_RK_CACHE_EN
            cache_valid_q <= cache_valid_d;
            replay_q      <= replay_d;
`endif
        end
    end

`ifdef AES_RK_CACHE_EN
    // Each freshly expanded key is stored in its round slot while it is presented
    always_ff @(posedge clk) begin
        if (state_q == HOLD && !replay_q) begin
            cache_q[round_q] <= rk_q;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_key_gen.sv
// tb/tb_aes_round_key_gen.sv - self-checking bench for aes_round_key_gen against a word-array key expansion model
module tb_aes_round_key_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         replay_i = 1'b0;
    logic [127:0] rk_o;
    logic [3:0]   rk_round_o;
    logic         rk_valid_o;
    logic         rk_ready_i = 1'b1;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int failures = 0;
    int max_round = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];

    aes_round_key_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .key_i      (key_i),
        .replay_i   (replay_i),
        .rk_o       (rk_o),
        .rk_round_o (rk_round_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box table from the cyclic generator walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // Textbook 44-word expansion
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full key stream: start (or replay), consume with optional stall and a stray start pulse
    task automatic run(input logic [127:0] k, input bit use_replay, input int stall_round,
                       input int stall_len, input int inject_round);
        int cyc, nk, stall_left, done_cyc, exp_arr, exp_done;
        bit seen, injected;
        logic [127:0] held;
        if (!use_replay) build_model(k);
        @(posedge clk); #1;
        if (use_replay) replay_i = 1'b1; else start_i = 1'b1;
        key_i = k;
        rk_ready_i = 1'b1;
        @(posedge clk); #1;
        replay_i = 1'b0;
        start_i = 1'b0;
        cyc = 0; nk = 0; stall_left = stall_len; done_cyc = -1; seen = 0; injected = 0; held = '0;
        while (cyc < 200 && done_cyc < 0) begin
            start_i = 1'b0;
            if (int'(rk_round_o) > max_round) max_round = int'(rk_round_o);
            if (done_o) begin
                done_cyc = cyc;
                chk("busy_at_done", busy_o, 0);
                chk("valid_at_done", rk_valid_o, 0);
            end else if (rk_valid_o) begin
                if (!seen) begin
                    seen = 1;
                    held = rk_o;
                    got_rk[nk] = rk_o;
                    exp_arr = use_replay ? nk
                                         : 5*nk + ((stall_round >= 0 && nk > stall_round) ? stall_len : 0);
                    chk($sformatf("round_idx_%0d", nk), rk_round_o, nk);
                    chk($sformatf("key_round_%0d", nk), rk_o, exp_rk[nk]);
                    chk($sformatf("arrival_round_%0d", nk), cyc, exp_arr);
                    chk("busy_running", busy_o, 1);
                end else begin
                    chk($sformatf("stall_key_%0d", nk), rk_o, held);
                    chk($sformatf("stall_round_%0d", nk), rk_round_o, nk);
                end
                if (int'(rk_round_o) == stall_round && stall_left > 0) begin
                    rk_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    rk_ready_i = 1'b1;
                end
                if (nk == inject_round && !injected) begin
                    injected = 1;
                    start_i = 1'b1;
                    key_i = ~k;
                end
                if (rk_ready_i) begin
                    nk++;
                    seen = 0;
                end
            end else begin
                rk_ready_i = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        exp_done = use_replay ? 11 : 51 + ((stall_round >= 0) ? stall_len : 0);
        chk("done_cycle", done_cyc, exp_done);
        chk("keys_consumed", nk, 11);
        chk("done_is_pulse", done_o, 0);
    endtask

    initial begin
        logic [127:0] k;
        build_sbox();

        // reset values while rst is high
        #1;
        chk("rst_rk", rk_o, 0);
        chk("rst_round", rk_round_o, 0);
        chk("rst_valid", rk_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // replay with nothing cached is ignored
        replay_i = 1'b1;
        @(posedge clk); #1;
        replay_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("replay_empty_busy", busy_o, 0);
        chk("replay_empty_valid", rk_valid_o, 0);

        // FIPS-197 vector, ready held high
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        run(k, 0, -1, 0, -1);
        chk("fips_round0", got_rk[0], k);
        chk("fips_round1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_RK_CACHE_EN
        run(k, 1, -1, 0, -1);
`else
        replay_i = 1'b1;
        @(posedge clk); #1;
        replay_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("replay_nocache_busy", busy_o, 0);
        chk("replay_nocache_valid", rk_valid_o, 0);
`endif

        // backpressure at round 3
        run(k, 0, 3, 7, -1);

        // stray start at round 5, then all-zero key
        run(k, 0, -1, 0, 5);
        run(128'h0, 0, -1, 0, -1);
        chk("zero_key_round1", got_rk[1], 128'h62636363626363636263636362636363);

        // reset in the middle of expanding round 4
        @(posedge clk); #1;
        start_i = 1'b1;
        key_i = k;
        rk_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_round", rk_round_o, 3);
        rst = 1'b1;
        #1;
        chk("midrst_rk", rk_o, 0);
        chk("midrst_round", rk_round_o, 0);
        chk("midrst_valid", rk_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run({$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, -1);

        // randomized keys and stalls
        for (int n = 0; n < 3; n++) begin
            run({$urandom, $urandom, $urandom, $urandom}, 0,
                int'($urandom_range(0, 10)), int'($urandom_range(1, 6)), -1);
        end

        chk("max_round", max_round, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
